// File: rtl/cache_mem_pkg.sv
// Shared types and sizing constants for the cache-to-memory arbiter.
package cache_mem_pkg;

  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;
  localparam int OFFSET_BITS     = 3;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int CNT_W           = OFFSET_BITS + 1;

  // Clears the word-offset bits to get a block-aligned base address.
  localparam logic [ADDR_W-1:0] BLOCK_MASK =
    {{(ADDR_W-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

  localparam logic [CNT_W-1:0] WORDS_CNT = CNT_W'(WORDS_PER_BLOCK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache fills, D-cache fills and D-cache write-through stores
// onto a single pipelined main memory port.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no access in flight; picks store > starved I > D > I each cycle
// FILL  | issues 8 back-to-back reads, steers returns to the granted cache
// WRITE | one-cycle store to memory, acknowledged to the D-cache
module mem_arbiter
  import cache_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              i_fill_valid,
  output logic [DATA_W-1:0] i_fill_data,
  output logic [ADDR_W-1:0] i_fill_addr,
  output logic              d_fill_valid,
  output logic [DATA_W-1:0] d_fill_data,
  output logic [ADDR_W-1:0] d_fill_addr,
  output logic              d_wr_ack,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_data_valid
);

  state_e            state_q,     state_d;
  gnt_e              gnt_q,       gnt_d;
  logic [ADDR_W-1:0] base_q,      base_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  ret_cnt_q,   ret_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
  logic [DATA_W-1:0] wr_data_q,   wr_data_d;
  logic              i_starve_q,  i_starve_d;

  logic [CNT_W-1:0]  ret_cnt_inc;
  logic              issuing;

  assign ret_cnt_inc = ret_cnt_q + CNT_W'(1);
  assign issuing     = (state_q == FILL) && (issue_cnt_q < WORDS_CNT);

  // Next-state logic: arbitration in IDLE, counter advance in FILL.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    i_starve_d  = i_starve_q;

    unique case (state_q)
      IDLE: begin
        if (d_wr_req) begin
          wr_addr_d = d_wr_addr;
          wr_data_d = d_wr_data;
          state_d   = WRITE;
        end else if (i_req && (i_starve_q || !d_req)) begin
          gnt_d       = GNT_I;
          base_d      = i_addr & BLOCK_MASK;
          i_starve_d  = 1'b0;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          state_d     = FILL;
        end else if (d_req) begin
          gnt_d       = GNT_D;
          base_d      = d_addr & BLOCK_MASK;
          // I lost this round; it wins the next one regardless of d_req.
          if (i_req) i_starve_d = 1'b1;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          state_d     = FILL;
        end
      end

      WRITE: begin
        state_d = IDLE;
      end

      FILL: begin
        if (issuing) issue_cnt_d = issue_cnt_q + CNT_W'(1);
        if (mem_data_valid) begin
          ret_cnt_d = ret_cnt_inc;
          if (ret_cnt_inc == WORDS_CNT) begin
            issue_cnt_d = '0;
            ret_cnt_d   = '0;
            state_d     = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any fill in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_I;
      base_q      <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      i_starve_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      i_starve_q  <= i_starve_d;
    end
  end

  // Memory-side strobes: reads while issuing in FILL, a single write in WRITE.
  // Offsets stay below WORDS_PER_BLOCK, so base + offset never leaves the block.
  always_comb begin
    mem_enable = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    d_wr_ack   = 1'b0;
    if (state_q == WRITE) begin
      mem_enable = 1'b1;
      mem_wr     = 1'b1;
      mem_addr   = wr_addr_q;
      mem_wdata  = wr_data_q;
      d_wr_ack   = 1'b1;
    end else if (issuing) begin
      mem_enable = 1'b1;
      mem_addr   = base_q + ADDR_W'(issue_cnt_q[OFFSET_BITS-1:0]);
    end
  end

  // Return steering: forward each returning word to the granted cache only.
  always_comb begin
    i_fill_valid = 1'b0;
    i_fill_data  = '0;
    i_fill_addr  = '0;
    d_fill_valid = 1'b0;
    d_fill_data  = '0;
    d_fill_addr  = '0;
    if ((state_q == FILL) && mem_data_valid) begin
      if (gnt_q == GNT_I) begin
        i_fill_valid = 1'b1;
        i_fill_data  = mem_rdata;
        i_fill_addr  = base_q + ADDR_W'(ret_cnt_q[OFFSET_BITS-1:0]);
      end else begin
        d_fill_valid = 1'b1;
        d_fill_data  = mem_rdata;
        d_fill_addr  = base_q + ADDR_W'(ret_cnt_q[OFFSET_BITS-1:0]);
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 4-cycle pipelined memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr_req;
  logic [15:0] i_addr, d_addr, d_wr_addr, d_wr_data;
  logic        i_fill_valid, d_fill_valid, d_wr_ack;
  logic [15:0] i_fill_data, i_fill_addr, d_fill_data, d_fill_addr;
  logic        mem_enable, mem_wr, mem_data_valid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_addr(d_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .i_fill_valid(i_fill_valid), .i_fill_data(i_fill_data), .i_fill_addr(i_fill_addr),
    .d_fill_valid(d_fill_valid), .d_fill_data(d_fill_data), .d_fill_addr(d_fill_addr),
    .d_wr_ack(d_wr_ack),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid)
  );

  // Memory contents as a fixed function of the word address.
  function automatic logic [15:0] mdata(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Pipelined memory: a read issued in cycle T returns valid in cycle T+4.
  logic [3:0]  pv;
  logic [15:0] pd0, pd1, pd2, pd3;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv <= '0; pd0 <= '0; pd1 <= '0; pd2 <= '0; pd3 <= '0;
    end else begin
      pv  <= {pv[2:0], mem_enable && !mem_wr};
      pd0 <= mdata(mem_addr);
      pd1 <= pd0;
      pd2 <= pd1;
      pd3 <= pd2;
    end
  end
  assign mem_data_valid = pv[3];
  assign mem_rdata      = pd3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Follows one fill: checks contiguous issue addresses, 4-cycle latency,
  // returned addresses/data on the granted side. Optionally raises a store
  // request after wr_at reads have been issued.
  task automatic run_fill(input logic is_i, input logic [15:0] base, input int wr_at,
                          input string tag);
    int issue_n = 0;
    int ret_n   = 0;
    int first   = -1;
    int cyc     = 0;
    for (int k = 0; k < 40 && ret_n < 8; k++) begin
      tick();
      cyc++;
      if (mem_enable) begin
        chk({tag, " rd_not_wr"}, mem_wr, 0);
        chk({tag, " rd_addr"}, mem_addr, 16'(base + issue_n));
        if (issue_n == 0) first = cyc;
        else chk({tag, " rd_b2b"}, cyc - first, issue_n);
        issue_n++;
        if (issue_n == wr_at) begin
          d_wr_req  = 1'b1;
          d_wr_addr = 16'h3008;
          d_wr_data = 16'h1234;
        end
      end
      if (is_i ? i_fill_valid : d_fill_valid) begin
        if (ret_n == 0) chk({tag, " latency"}, cyc - first, 4);
        chk({tag, " fill_addr"}, is_i ? i_fill_addr : d_fill_addr, 16'(base + ret_n));
        chk({tag, " fill_data"}, is_i ? i_fill_data : d_fill_data, mdata(16'(base + ret_n)));
        chk({tag, " other_side"}, is_i ? d_fill_valid : i_fill_valid, 0);
        ret_n++;
      end
    end
    chk({tag, " issues"}, issue_n, 8);
    chk({tag, " returns"}, ret_n, 8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int got;
    int n;
    rst = 1'b0;
    i_req = 0; d_req = 0; d_wr_req = 0;
    i_addr = 0; d_addr = 0; d_wr_addr = 0; d_wr_data = 0;

    // Reset state
    tick(); tick();
    chk("rst mem_enable", mem_enable, 0);
    chk("rst mem_wr", mem_wr, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst i_fill_valid", i_fill_valid, 0);
    chk("rst d_fill_valid", d_fill_valid, 0);
    chk("rst d_wr_ack", d_wr_ack, 0);
    rst = 1'b1;
    tick();

    // I fill alone, unaligned miss address
    i_addr = 16'h0A4C; i_req = 1'b1;
    run_fill(1'b1, 16'h0A48, -1, "t2");
    i_req = 1'b0;
    tick();
    chk("t2 idle1 mem_enable", mem_enable, 0);
    tick();
    chk("t2 idle2 mem_enable", mem_enable, 0);
    chk("t2 idle2 i_fill_valid", i_fill_valid, 0);

    // Simultaneous I and D: D first, then starved I despite d_req still high
    i_addr = 16'h0100; d_addr = 16'h2200;
    i_req = 1'b1; d_req = 1'b1;
    run_fill(1'b0, 16'h2200, -1, "t3d");
    d_addr = 16'h2240;
    run_fill(1'b1, 16'h0100, -1, "t3i");
    i_req = 1'b0;
    run_fill(1'b0, 16'h2240, -1, "t3d2");
    d_req = 1'b0;
    tick();

    // Store concurrent with a D fill request: store goes first
    d_addr = 16'h3010; d_req = 1'b1;
    d_wr_addr = 16'h3004; d_wr_data = 16'hBEEF; d_wr_req = 1'b1;
    got = 0;
    for (int k = 0; k < 10 && got == 0; k++) begin
      tick();
      if (mem_enable) begin
        got = 1;
        chk("t4 mem_wr", mem_wr, 1);
        chk("t4 mem_addr", mem_addr, 16'h3004);
        chk("t4 mem_wdata", mem_wdata, 16'hBEEF);
        chk("t4 d_wr_ack", d_wr_ack, 1);
        d_wr_req = 1'b0;
      end
    end
    chk("t4 write seen", got, 1);
    tick();
    chk("t4 ack pulse", d_wr_ack, 0);
    chk("t4 no 2nd write", mem_enable & mem_wr, 0);
    run_fill(1'b0, 16'h3010, -1, "t4");
    d_req = 1'b0;
    tick();

    // Store raised during an I fill waits until the fill completes
    i_addr = 16'h0400; i_req = 1'b1;
    run_fill(1'b1, 16'h0400, 3, "t5");
    i_req = 1'b0;
    got = 0;
    for (int k = 0; k < 3 && got == 0; k++) begin
      tick();
      if (mem_enable) begin
        got = 1;
        chk("t5 mem_wr", mem_wr, 1);
        chk("t5 mem_addr", mem_addr, 16'h3008);
        chk("t5 mem_wdata", mem_wdata, 16'h1234);
        chk("t5 d_wr_ack", d_wr_ack, 1);
        d_wr_req = 1'b0;
      end
    end
    chk("t5 write seen", got, 1);
    tick();
    chk("t5 ack pulse", d_wr_ack, 0);

    // Reset mid-fill after three returns, then refill from word +0
    d_addr = 16'h1238; d_req = 1'b1;
    n = 0;
    for (int k = 0; k < 30 && n < 3; k++) begin
      tick();
      if (d_fill_valid) n++;
    end
    chk("t1 three returns", n, 3);
    rst = 1'b0;
    #1;
    chk("t1 rst mem_enable", mem_enable, 0);
    chk("t1 rst mem_addr", mem_addr, 0);
    chk("t1 rst d_fill_valid", d_fill_valid, 0);
    chk("t1 rst d_fill_data", d_fill_data, 0);
    chk("t1 rst d_fill_addr", d_fill_addr, 0);
    chk("t1 rst i_fill_valid", i_fill_valid, 0);
    chk("t1 rst d_wr_ack", d_wr_ack, 0);
    tick();
    rst = 1'b1;
    run_fill(1'b0, 16'h1238, -1, "t1");
    d_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the I-cache and D-cache fill FSMs and upstream of the shared pipelined main memory.
- Accepts block-fill requests from both caches and single-word write-through stores from the D-cache.
- Grants one requester at a time and issues the 8 word reads of a block back-to-back.
- Steers returning words, each tagged with its word address, to the granted cache.

Parameters:
- MEM_LATENCY, 4, cycles from a memory read being issued (mem_enable high, mem_wr low) to mem_data_valid for that word.
- WORDS_PER_BLOCK, 8, words per cache block; a fill covers block base address +0 through +7.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_req  in  1  I-cache fill request; held high until its last i_fill_valid.
- i_addr  in  16  I-cache miss address; bits [2:0] ignored.
- d_req  in  1  D-cache fill request; same hold rule as i_req.
- d_addr  in  16  D-cache miss address; bits [2:0] ignored.
- d_wr_req  in  1  D-cache write-through request; held high until d_wr_ack.
- d_wr_addr  in  16  store word address.
- d_wr_data  in  16  store data.
- i_fill_valid  out  1  i_fill_data/i_fill_addr valid this cycle.
- i_fill_data  out  16  returned word.
- i_fill_addr  out  16  word address of i_fill_data.
- d_fill_valid  out  1  D-side equivalent of i_fill_valid.
- d_fill_data  out  16  D-side equivalent of i_fill_data.
- d_fill_addr  out  16  D-side equivalent of i_fill_addr.
- d_wr_ack  out  1  one-cycle pulse: store issued to memory.
- mem_enable  out  1  memory access strobe.
- mem_wr  out  1  1 = write, 0 = read.
- mem_addr  out  16  memory word address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data.
- mem_data_valid  in  1  mem_rdata valid.

Behaviour:
Reset:
- All outputs 0, state IDLE, counters 0, i_starve 0.
- Memory shares rst, so no stale returns survive reset.
- Reset mid-fill aborts the fill; the requester re-requests after reset.

States: IDLE, FILL, WRITE.

IDLE, evaluated each cycle in this priority order:
- d_wr_req -> latch d_wr_addr/d_wr_data, go to WRITE.
- Else if i_req && (i_starve || !d_req) -> grant I, latch base = {i_addr[15:3], 3'b000}, clear i_starve, go to FILL.
- Else if d_req -> grant D, latch base from d_addr; set i_starve if i_req is also high; go to FILL.
- mem_data_valid in IDLE is ignored.

WRITE (exactly 1 cycle):
- mem_enable=1, mem_wr=1, mem_addr/mem_wdata from the latched values, d_wr_ack=1.
- Next state IDLE.
- A requester must drop d_wr_req on the cycle after ack. A still-high d_wr_req starts a new write; this is legal for back-to-back stores.

FILL:
- Issue counter 0..7: each cycle with issue count < 8, drive mem_enable=1, mem_wr=0, mem_addr = base + issue count.
- Reads occupy the first 8 FILL cycles; the first word returns MEM_LATENCY cycles after the first issue.
- Return counter: on each mem_data_valid, pulse the granted side's fill_valid combinationally in the same cycle, with fill_data = mem_rdata and fill_addr = base + return count; increment the counter.
- The non-granted side's fill_valid stays 0.
- After the 8th return, go to IDLE.
- Total FILL occupancy = WORDS_PER_BLOCK + MEM_LATENCY cycles (12 at defaults).

Boundary conditions:
- Requests arriving during FILL/WRITE wait; no preemption.
- Requester dropping req mid-fill: the fill still completes all 8 returns.
- Counters are log2(WORDS_PER_BLOCK) + 1 bits wide.
- base + offset never carries into bit 3 and above because base is block-aligned; mem_addr must not wrap outside the block.
- i_starve guarantees the I-cache is served at most one D-fill after it first loses arbitration. Stores still outrank it.

Decomposition:
- Shared package cache_mem_pkg holds:
  - the state enum {IDLE, FILL, WRITE};
  - the grant enum {GNT_I, GNT_D};
  - constants WORDS_PER_BLOCK, OFFSET_BITS=3, ADDR_W=16, DATA_W=16.
- No sub-module required; the issue and return counters stay inline in one module.

Test Plan:
1. Reset asserted mid-fill (after 3 returns) -> all outputs 0 immediately; after release, d_req at 0x1238 re-fills from base 0x1238 word +0.
2. i_req, i_addr=0x0A4C, D idle -> mem_addr 0x0A48..0x0A4F on 8 consecutive cycles; i_fill_valid pulses 8 times starting 4 cycles after the first issue; i_fill_addr 0x0A48..0x0A4F with the matching data; back to IDLE.
3. i_req and d_req rise in the same cycle (0x0100, 0x2200) -> D served first (base 0x2200), then I (0x0100) with no D re-grant even though d_req is reasserted.
4. d_wr_req (0x3004, 0xBEEF) concurrent with d_req -> WRITE first: mem_wr=1, mem_addr=0x3004, mem_wdata=0xBEEF, d_wr_ack for 1 cycle; fill starts the next cycle.
5. d_wr_req raised during an I fill -> no memory write until the 8th i_fill_valid; WRITE in the following cycle; I fill data unaffected.
